// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Checks alignment/funct3 legality and returns a registered 1-cycle response.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [2:0]            p0_req_funct3,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [2:0]            p1_req_funct3,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    logic                  last_grant_q, last_grant_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_port_q, rsp_port_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  gnt0, gnt1, gnt_any;
    logic                  sel_we;
    logic [2:0]            sel_f3;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  legal;

    // Tie goes to the port that did not win last; nothing is granted in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (p0_req_valid && p1_req_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = p0_req_valid;
                gnt1 = p1_req_valid;
            end
        end
    end

    assign gnt_any      = gnt0 | gnt1;
    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    assign sel_we    = gnt1 ? p1_req_we     : p0_req_we;
    assign sel_f3    = gnt1 ? p1_req_funct3 : p0_req_funct3;
    assign sel_addr  = gnt1 ? p1_req_addr   : p0_req_addr;
    assign sel_wdata = gnt1 ? p1_req_wdata  : p0_req_wdata;

    always_comb begin
        legal = 1'b0;
        unique case (sel_f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = !sel_addr[0];
            3'b010:  legal = (sel_addr[1:0] == 2'b00);
            3'b100:  legal = !sel_we;
            3'b101:  legal = !sel_we && !sel_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        mem_wr_en   = gnt_any && legal && sel_we;
        mem_funct3  = gnt_any ? sel_f3    : 3'b000;
        mem_addr    = gnt_any ? sel_addr  : '0;
        mem_wr_data = gnt_any ? sel_wdata : '0;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        rsp_port_d   = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        if (gnt_any) begin
            last_grant_d = gnt1;
            rsp_valid_d  = 1'b1;
            rsp_port_d   = gnt1;
            rsp_err_d    = !legal;
            if (legal && !sel_we) begin
                rsp_rdata_d = mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Only the owning port sees the response; the other reads all-zero.
    always_comb begin
        p0_rsp_valid = rsp_valid_q && !rsp_port_q;
        p1_rsp_valid = rsp_valid_q && rsp_port_q;
        p0_rsp_err   = p0_rsp_valid && rsp_err_q;
        p1_rsp_err   = p1_rsp_valid && rsp_err_q;
        p0_rsp_rdata = p0_rsp_valid ? rsp_rdata_q : '0;
        p1_rsp_rdata = p1_rsp_valid ? rsp_rdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model
// that returns sign/zero-extended read data like the real data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [2:0]  p0_req_funct3;
    logic [31:0] p0_req_addr, p0_req_wdata;
    logic        p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we;
    logic [2:0]  p1_req_funct3;
    logic [31:0] p1_req_addr, p1_req_wdata;
    logic        p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_rsp_rdata;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_we(p0_req_we), .p0_req_funct3(p0_req_funct3),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_we(p1_req_we), .p1_req_funct3(p1_req_funct3),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    logic [7:0]  mem [0:255];
    logic        init_done = 1'b0;
    logic [7:0]  ma;
    logic [31:0] mw;

    // Preload on the first edge (inside reset), then behave as the memory.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            for (int b = 0; b < 4; b++) begin
                mem[8'h40 + b] <= 8'(32'h1111_2222 >> (8 * b));
                mem[8'h44 + b] <= 8'(32'h3333_4444 >> (8 * b));
                mem[8'h30 + b] <= 8'(32'hCAFE_F00D >> (8 * b));
            end
            init_done <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr[7:0]] <= mem_wr_data[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_addr[7:0] + 8'd1] <= mem_wr_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wr_data[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wr_data[31:24];
            end
        end
    end

    always_comb begin
        ma = mem_addr[7:0];
        mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{mw[7]}}, mw[7:0]};
            3'b001:  mem_rd_data = {{16{mw[15]}}, mw[15:0]};
            3'b100:  mem_rd_data = {24'h0, mw[7:0]};
            3'b101:  mem_rd_data = {16'h0, mw[15:0]};
            default: mem_rd_data = mw;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        check(tag, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic set0(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        p0_req_valid = v; p0_req_we = we; p0_req_funct3 = f3;
        p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        p1_req_valid = v; p1_req_we = we; p1_req_funct3 = f3;
        p1_req_addr = a; p1_req_wdata = d;
    endtask

    task automatic chk_rsp(input string tag, input logic v0, input logic v1,
                           input logic err, input logic [31:0] rd);
        check1({tag, ".p0_rsp_valid"}, p0_rsp_valid, v0);
        check1({tag, ".p1_rsp_valid"}, p1_rsp_valid, v1);
        if (v0) begin
            check1({tag, ".p0_err"}, p0_rsp_err, err);
            check({tag, ".p0_rdata"}, p0_rsp_rdata, rd);
            check({tag, ".p1_rdata_idle"}, p1_rsp_rdata, 32'h0);
        end else if (v1) begin
            check1({tag, ".p1_err"}, p1_rsp_err, err);
            check({tag, ".p1_rdata"}, p1_rsp_rdata, rd);
            check({tag, ".p0_rdata_idle"}, p0_rsp_rdata, 32'h0);
        end
    endtask

    logic        e0;
    logic        bad_we [3]  = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  bad_f3 [3]  = '{3'b001, 3'b010, 3'b100};
    logic [31:0] bad_ad [3]  = '{32'h13, 32'h22, 32'h20};

    initial begin
        reset = 1'b1;
        set0(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        set1(1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
        repeat (2) begin
            @(negedge clk); #1;
            check1("rst.p0_ready", p0_req_ready, 1'b0);
            check1("rst.p1_ready", p1_req_ready, 1'b0);
            check1("rst.mem_wr_en", mem_wr_en, 1'b0);
            @(posedge clk); #1;
            chk_rsp("rst", 1'b0, 1'b0, 1'b0, 32'h0);
        end

        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            e0 = (k % 2 == 0);
            check1($sformatf("rr%0d.p0_ready", k), p0_req_ready, e0);
            check1($sformatf("rr%0d.p1_ready", k), p1_req_ready, !e0);
            check($sformatf("rr%0d.mem_addr", k), mem_addr,
                  e0 ? 32'h40 : 32'h44);
            @(posedge clk); #1;
            chk_rsp($sformatf("rr%0d", k), e0, !e0, 1'b0,
                    e0 ? 32'h1111_2222 : 32'h3333_4444);
            @(negedge clk);
        end

        set1(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set0(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        #1;
        check1("sw.p0_ready", p0_req_ready, 1'b1);
        check1("sw.mem_wr_en", mem_wr_en, 1'b1);
        check("sw.mem_addr", mem_addr, 32'h10);
        check("sw.mem_wr_data", mem_wr_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk_rsp("sw", 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        check1("lw.mem_wr_en", mem_wr_en, 1'b0);
        @(posedge clk); #1;
        chk_rsp("lw", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

        set0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set1(1'b1, bad_we[i], bad_f3[i], bad_ad[i], 32'hAAAA_5555);
            #1;
            check1($sformatf("bad%0d.p1_ready", i), p1_req_ready, 1'b1);
            check1($sformatf("bad%0d.mem_wr_en", i), mem_wr_en, 1'b0);
            @(posedge clk); #1;
            chk_rsp($sformatf("bad%0d", i), 1'b0, 1'b1, 1'b1, 32'h0);
        end
        @(negedge clk);
        set1(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #1;
        chk_rsp("relw", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);

        @(negedge clk);
        set1(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set0(1'b1, 1'b1, 3'b000, 32'h21, 32'h80);
        #1;
        check1("sb.mem_wr_en", mem_wr_en, 1'b1);
        @(posedge clk); #1;
        chk_rsp("sb", 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set0(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
        @(posedge clk); #1;
        chk_rsp("lb", 1'b1, 1'b0, 1'b0, 32'hFFFF_FF80);
        @(negedge clk);
        set0(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
        @(posedge clk); #1;
        chk_rsp("lbu", 1'b1, 1'b0, 1'b0, 32'h0000_0080);

        @(negedge clk);
        set0(1'b1, 1'b1, 3'b010, 32'h30, 32'h1234_5678);
        reset = 1'b1;
        #1;
        check1("midrst.p0_ready", p0_req_ready, 1'b0);
        check1("midrst.mem_wr_en", mem_wr_en, 1'b0);
        @(posedge clk); #1;
        chk_rsp("midrst", 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        set0(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        #1;
        check1("postrst.p0_ready", p0_req_ready, 1'b1);
        @(posedge clk); #1;
        chk_rsp("postrst", 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);

        @(negedge clk);
        set0(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk_rsp("idle", 1'b0, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. The core load/store port (port 0) and a secondary master such as a debug or DMA engine (port 1) share the memory. The block grants one request per cycle using round-robin fairness and drives the memory's write enable, funct3, address and write data. It checks each request for alignment and legal funct3 before touching memory, then returns a registered response with an error flag to the granted port.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- p0_req_valid / p1_req_valid  in  1  request present; held stable until ready
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle
- p0_req_we / p1_req_we  in  1  1 = store, 0 = load
- p0_req_funct3 / p1_req_funct3  in  3  RISC-V load/store funct3
- p0_req_addr / p1_req_addr  in  ADDR_WIDTH  byte address
- p0_req_wdata / p1_req_wdata  in  DATA_WIDTH  store data, right-aligned
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle response pulse
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_WIDTH  load result (extended as memory returns it); 0 for stores/errors
- p0_rsp_err / p1_rsp_err  out  1  misaligned or illegal funct3
- mem_wr_en  out  1  memory write strobe
- mem_funct3  out  3  funct3 to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_wr_data  out  DATA_WIDTH  write data to memory
- mem_rd_data  in  DATA_WIDTH  combinational read data from memory

## Operation
- Arbitration is combinational within the cycle.
  - Exactly one valid requester: that port is granted.
  - Both valid: grant the port that is not `last_grant`.
  - `last_grant` register resets to 1, so port 0 wins the first tie.
- `last_grant` updates to the granted port on every grant.
- px_req_ready = grant to port x. Ready is asserted in the same cycle as valid, so an uncontested request is accepted with zero wait.
- Legality check on the granted request:
  - Loads accept funct3 000, 001, 010, 100, 101.
  - Stores accept funct3 000, 001, 010.
  - Halfword (001/101) requires addr[0]=0.
  - Word (010) requires addr[1:0]=00.
  - Anything else is an error.
- Legal access: mem_funct3, mem_addr and mem_wr_data follow the granted request. mem_wr_en = we.
- Error access: mem_wr_en = 0, so memory is never written. The response still returns with err=1 and rdata=0.
- No grant: mem_wr_en = 0 and the other mem_* outputs hold 0.
- Response registers capture at the end of the grant cycle:
  - rsp_port, rsp_valid and err.
  - rdata = mem_rd_data for a legal load, else 0.
- Only the owning port sees rsp_valid. The other port's rsp_* outputs are 0.
- Responses cannot be backpressured. Requesters must accept the rsp_valid pulse.
- A port may issue back-to-back requests. Each accepted request yields exactly one response, in order.

## Timing
- Reset values: all ready=0 (combinational, forced 0 while reset=1), all rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0, last_grant=1.
- Accept in cycle N leads to rsp_valid in cycle N+1. Latency is fixed at 1 cycle.
- Store data is written at the rising edge ending cycle N.
- Throughput: 1 access per cycle in aggregate. Under continuous contention each port gets every other cycle.
- Simultaneous events:
  - Both ports request in the same cycle as a response is issued: no conflict, the response path is registered.
  - A load and a store to the same word in successive cycles: the load sees the new data, since the write completes at the end of cycle N.
- Reset asserted mid-operation: the pending response is dropped (rsp_valid=0 next cycle), and any write strobe in the reset cycle is suppressed.
- No starvation: a continuously valid port waits at most 1 cycle.

## Test plan
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles with both valid=1.
  - Required: ready=0, rsp_valid=0 and mem_wr_en=0 throughout.
  - Required: first cycle after reset grants port 0.
- Single-port store then load:
  - Stimulus: p0 `sw` 0xDEADBEEF @0x10, then p0 `lw` @0x10.
  - Required: p0 rsp_valid in cycles N+1 and N+2, err=0.
  - Required: second response rdata=0xDEADBEEF.
- Contention round-robin:
  - Stimulus: both ports hold `lw` requests for 6 cycles.
  - Required: grants alternate p0, p1, p0, p1, p0, p1.
  - Required: each rsp_valid goes only to the matching port one cycle later.
- Misaligned and illegal:
  - Stimulus: p1 `sh` @0x13, p1 `lw` @0x22, p1 store funct3=100.
  - Required: each returns err=1, rdata=0, and mem_wr_en stays 0.
  - Required: a follow-up `lw` @0x10 still returns the prior word.
- Sub-word paths:
  - Stimulus: `sb` 0x80 @0x21, then `lb` @0x21, then `lbu` @0x21.
  - Required: `lb` returns rdata=0xFFFFFF80, `lbu` returns rdata=0x00000080.
- Reset mid-traffic:
  - Stimulus: assert reset in the cycle p0's `sw` 0x12345678 @0x30 is granted.
  - Required: memory unchanged (a subsequent `lw` @0x30 returns the old value) and no rsp_valid pulse.
